main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Responder end of the cache-fill / write-through protocol. I and D caches arbitrate at the memory wrapper for one
//  shared request port; this block serves that port. Read request -> full aligned 8-word block returned one beat per
//  cycle after fixed latency; write request -> single 16-bit word stored after fixed latency. Replaces the opaque
//  4-cycle main memory with a visible FSM exposing req_ready/rsp_valid.
// PARAMETERS
//  ADDR_W      16  byte-address width; word index = addr[ADDR_W-1:1]
//  DEPTH_W     15  log2 of word count in backing array (2^15 x 16b = 64 KB)
//  LATENCY     4   cycles from accepted request to first read beat / write completion (>=1)
//  BLOCK_WORDS 8   words per cache block (power of two; 8 -> 16-byte block)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       responder idle, request accepted when req_valid & req_ready
//  req_wr      in   1       1 = single-word write, 0 = block read
//  req_addr    in   ADDR_W  byte address (bit 0 ignored)
//  req_data    in   16      write data
//  rsp_valid   out  1       read beat valid this cycle
//  rsp_addr    out  ADDR_W  byte address of current beat
//  rsp_data    out  16      read beat data
//  rsp_last    out  1       final beat of block (with rsp_valid)
//  wr_done     out  1       one-cycle pulse: write committed
//  busy        out  1       ~req_ready
// BEHAVIOUR
//  - Reset: FSM=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_last=0, wr_done=0, rsp_addr=0, rsp_data=0, counters=0.
//    Array contents NOT cleared by rst (preload via bench/$readmemh).
//  - States: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
//  - IDLE: req_ready=1. On req_valid: latch addr/data; lat_cnt<=LATENCY-1; go RD_WAIT (req_wr=0) or WR_WAIT (req_wr=1).
//  - RD_WAIT: lat_cnt decrements; at 0 -> RD_BURST, beat<=0. Block base = req_addr with low log2(BLOCK_WORDS)+1 bits 0.
//  - RD_BURST: each cycle rsp_valid=1, rsp_addr=base+2*beat, rsp_data=array[word(rsp_addr)]; beat increments.
//    beat==BLOCK_WORDS-1 -> rsp_last=1, next IDLE. Beats strictly ascending, no gaps, no critical-word-first.
//  - Latency: request accepted cycle T -> first beat cycle T+LATENCY, last beat T+LATENCY+BLOCK_WORDS-1;
//    req_ready=1 again cycle T+LATENCY+BLOCK_WORDS.
//  - WR_WAIT: lat_cnt counts down; at 0 write array[word(addr)]<=data, wr_done=1 that cycle, next IDLE
//    (req_ready back next cycle). Write accept T -> wr_done T+LATENCY.
//  - Requests while req_ready=0 ignored, no effect; requester must hold req_valid until accepted.
//  - Read-after-write: read accepted after wr_done sees new data (writes commit before next accept).
//  - Address wrap: word index taken modulo 2^DEPTH_W; high address bits beyond array silently aliased.
//  - rsp_data/rsp_addr hold last value when rsp_valid=0 (checker must gate on rsp_valid).
//  - rst mid-operation (any state): abort at once, next cycle IDLE per reset values; pending write dropped, no
//    partial burst continuation, no wr_done.
//  - Registered outputs only; no combinational path req_* -> rsp_*.
// STRUCTURE
//  - Shared package mem_pkg: state enum {IDLE,RD_WAIT,RD_BURST,WR_WAIT}, BLOCK_WORDS, BLOCK_OFFSET_W, LATENCY default;
//    same package used by cache fill FSM so both ends agree on block size.
//  - One sub-module: mem_word_array (2^DEPTH_W x 16, sync write, async read, single port); top holds FSM, lat_cnt, beat
//    counter, address/data latches.
// TESTING
//  1. rst held 2 cycles -> req_ready=1, busy=0, rsp_valid=0, wr_done=0; array preload intact.
//  2. Preload words 0x0010..0x001E = 0xA000..0xA007; read req_addr=0x0016 at T -> beats T+4..T+11, rsp_addr
//     0x0010..0x001E, data 0xA000..0xA007, rsp_last only at T+11, req_ready=1 at T+12.
//  3. Write 0x1234 to 0x0042 at T -> wr_done pulse T+4 only; then read 0x0040 -> beat 1 (0x0042) = 0x1234.
//  4. Second req_valid held during RD_BURST -> ignored until req_ready; then accepted, its burst starts 4 cycles later.
//  5. rst asserted at 3rd beat of burst -> next cycle IDLE, rsp_valid=0, no rsp_last; rst during WR_WAIT -> no write.
//  6. Read 0xFFF8 -> base 0xFFF0, beats 0xFFF0..0xFFFE, wrap of word index at top of array checked, no overflow.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
//============================================================================
// Module  : mem_pkg
// Brief   : Shared block geometry, latency default and responder FSM states.
// Revision: 1.0
//============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    localparam int BLOCK_WORDS     = 8;
    localparam int BEAT_W          = $clog2(BLOCK_WORDS);
    // Byte offset inside a block: beat index plus the ignored byte bit.
    localparam int BLOCK_OFFSET_W  = BEAT_W + 1;
    localparam int DEFAULT_LATENCY = 4;
    localparam int DATA_W          = 16;

endpackage

`default_nettype wire

// File: rtl/main_mem_responder_if.sv
//============================================================================
// Module  : main_mem_responder_if
// Brief   : Request/response bus between the cache-side arbiter and memory.
// Revision: 1.0
//============================================================================
`default_nettype none

interface main_mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_data;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic [15:0]       rsp_data;
    logic              rsp_last;
    logic              wr_done;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, wr_done, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_data,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, wr_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/main_mem_responder_word_array.sv
//============================================================================
// Module  : mem_word_array
// Brief   : Single-port word store, synchronous write, asynchronous read.
// Revision: 1.0
//============================================================================
`default_nettype none

module mem_word_array #(
    parameter int DEPTH_W = 15,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DEPTH_W-1:0] i_addr,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_rdata
);

    // Contents survive reset; the array is preloaded by its user.
    logic [DATA_W-1:0] r_mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/main_mem_responder.sv
//============================================================================
// Module  : main_mem_responder
// Brief   : Memory-side responder: fixed-latency block reads, word writes.
// Revision: 1.0
//============================================================================
`default_nettype none

module main_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 15,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]  c_lat_load  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BLOCK_WORDS - 1);

    state_t              r_state, w_state_nxt;
    logic [LAT_W-1:0]    r_lat_cnt, w_lat_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic                r_rsp_last, w_rsp_last_nxt;
    logic                r_wr_done, w_wr_done_nxt;
    logic [ADDR_W-1:0]   r_rsp_addr;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                w_load_rsp;
    logic                w_mem_we;
    logic                w_mem_we_g;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [DEPTH_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]   w_mem_rdata;

    // High address bits beyond the array alias silently.
    function automatic logic [DEPTH_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return DEPTH_W'(a >> 1);
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_nxt       = r_lat_cnt;
        w_beat_nxt      = r_beat;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_last_nxt  = 1'b0;
        w_wr_done_nxt   = 1'b0;
        w_load_rsp      = 1'b0;
        w_mem_we        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_addr_nxt      = bus.req_addr;
                    w_wdata_nxt     = bus.req_data;
                    w_lat_nxt       = c_lat_load;
                    w_beat_nxt      = '0;
                    w_req_ready_nxt = 1'b0;
                    if (bus.req_wr) begin
                        w_state_nxt   = WR_WAIT;
                        w_wr_done_nxt = (LATENCY == 1);
                    end else if (LATENCY == 1) begin
                        w_state_nxt     = RD_BURST;
                        w_rsp_valid_nxt = 1'b1;
                        w_load_rsp      = 1'b1;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                w_lat_nxt = r_lat_cnt - LAT_W'(1);
                // Beat 0 is registered on the last wait cycle so it lands exactly LATENCY after accept.
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_nxt     = RD_BURST;
                    w_beat_nxt      = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_load_rsp      = 1'b1;
                end
            end
            RD_BURST: begin
                if (r_beat == c_last_beat) begin
                    w_state_nxt     = IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_beat_nxt      = r_beat + BEAT_W'(1);
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_last_nxt  = (w_beat_nxt == c_last_beat);
                    w_load_rsp      = 1'b1;
                end
            end
            WR_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_mem_we        = 1'b1;
                    w_state_nxt     = IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_lat_nxt     = r_lat_cnt - LAT_W'(1);
                    w_wr_done_nxt = (r_lat_cnt == LAT_W'(1));
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    assign w_beat_addr = {w_addr_nxt[ADDR_W-1:BLOCK_OFFSET_W], w_beat_nxt, 1'b0};
    assign w_mem_we_g  = w_mem_we & ~rst;
    // Single port: the write owns the address only in its commit cycle, never during a burst.
    assign w_mem_addr  = w_mem_we ? word_idx(r_addr) : word_idx(w_beat_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_beat      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_beat      <= w_beat_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_wr_done   <= w_wr_done_nxt;
            if (w_load_rsp) begin
                r_rsp_addr <= w_beat_addr;
                r_rsp_data <= w_mem_rdata;
            end
        end
    end

    mem_word_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we_g),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = ~r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_addr  = r_rsp_addr;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.wr_done   = r_wr_done;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_responder.sv
//============================================================================
// Module  : tb_main_mem_responder
// Brief   : Randomized self-checking bench with a cycle-timed memory model.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_main_mem_responder;

    localparam int L     = 4;
    localparam int BW    = 8;
    localparam int DEPTH = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] model [int];

    main_mem_responder_if #(.ADDR_W(16)) bus ();

    main_mem_responder #(
        .ADDR_W  (16),
        .DEPTH_W (15),
        .LATENCY (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, bus.req_ready, 1'b1);
        check_eq({tag, "_busy"},  bus.busy,      1'b0);
        check_eq({tag, "_valid"}, bus.rsp_valid, 1'b0);
        check_eq({tag, "_last"},  bus.rsp_last,  1'b0);
        check_eq({tag, "_wrdone"},bus.wr_done,   1'b0);
        check_eq({tag, "_raddr"}, bus.rsp_addr,  16'h0);
        check_eq({tag, "_rdata"}, bus.rsp_data,  16'h0);
    endtask

    // Present a request and stay in the cycle where it is accepted.
    task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d);
        int w;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_data  = d;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check_eq("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_read(input logic [15:0] a, input bit chain, input logic [15:0] ca);
        int  base;
        int  ea;
        bit  exp_v;
        base = int'(a) - (int'(a) % (2 * BW));
        for (int k = 1; k <= L + BW; k++) begin
            step();
            if (k == 1) begin
                if (chain) begin
                    bus.req_wr   = 1'b0;
                    bus.req_addr = ca;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            exp_v = (k >= L) && (k < L + BW);
            check_eq("rd_valid", bus.rsp_valid, exp_v);
            check_eq("rd_ready", bus.req_ready, k == L + BW);
            check_eq("rd_busy",  bus.busy,      k != L + BW);
            if (exp_v) begin
                ea = (base + 2 * (k - L)) % 65536;
                check_eq("rd_addr", bus.rsp_addr, ea);
                check_eq("rd_last", bus.rsp_last, k == L + BW - 1);
                if (model.exists(widx(16'(ea))))
                    check_eq("rd_data", bus.rsp_data, model[widx(16'(ea))]);
            end
        end
    endtask

    task automatic do_read(input logic [15:0] a);
        issue(1'b0, a, 16'h0);
        check_read(a, 1'b0, 16'h0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        issue(1'b1, a, d);
        for (int k = 1; k <= L + 1; k++) begin
            step();
            if (k == 1) bus.req_valid = 1'b0;
            check_eq("wr_done",  bus.wr_done,   k == L);
            check_eq("wr_ready", bus.req_ready, k == L + 1);
            check_eq("wr_noval", bus.rsp_valid, 1'b0);
        end
        model[widx(a)] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset held two cycles.
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Block at 0x0010 preloaded, then read from a mid-block address.
        for (int i = 0; i < BW; i++) do_write(16'(16'h0010 + 2 * i), 16'(16'hA000 + i));
        do_read(16'h0016);

        // Contents survive a reset pulse.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst2");
        step();
        do_read(16'h0010);

        // Read-after-write on a fresh block.
        do_write(16'h0042, 16'h1234);
        do_read(16'h0040);

        // Request held during a burst is only taken once the responder is idle again.
        for (int i = 0; i < BW; i++) begin
            do_write(16'(16'h0200 + 2 * i), 16'($urandom));
            do_write(16'(16'h0300 + 2 * i), 16'($urandom));
        end
        issue(1'b0, 16'h0204, 16'h0);
        check_read(16'h0204, 1'b1, 16'h030A);
        check_read(16'h030A, 1'b0, 16'h0);

        // Reset on the third beat aborts the burst.
        issue(1'b0, 16'h0010, 16'h0);
        for (int k = 1; k <= L + 2; k++) begin
            step();
            if (k == 1) bus.req_valid = 1'b0;
        end
        check_eq("abort_beat3", bus.rsp_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("abort");
        for (int k = 0; k < BW; k++) begin
            step();
            check_eq("abort_noval", bus.rsp_valid, 1'b0);
        end

        // Reset during the write wait drops the write.
        issue(1'b1, 16'h0012, 16'h5555);
        step();
        bus.req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("wrabort");
        for (int k = 0; k < L + 2; k++) begin
            step();
            check_eq("wrabort_nodone", bus.wr_done, 1'b0);
        end
        do_read(16'h0012);

        // Top of the array and its neighbour at word 0.
        for (int i = 0; i < BW; i++) begin
            do_write(16'(16'hFFF0 + 2 * i), 16'(16'hB000 + i));
            do_write(16'(2 * i), 16'(16'hC000 + i));
        end
        do_read(16'hFFF8);
        do_read(16'h0001);

        // Randomized mix inside a preloaded region; bit 0 of the address varies freely.
        for (int i = 0; i < 64; i++) do_write(16'(16'h0100 + 2 * i), 16'($urandom));
        for (int n = 0; n < 30; n++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            a = 16'(16'h0100 + $urandom_range(0, 127));
            d = 16'($urandom);
            if ($urandom_range(0, 9) < 4) do_write(a, d);
            else                          do_read(a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
